// File: rtl/dram_bank_sched.sv
`default_nettype none
// ============================================================================
// Module   : dram_bank_sched
// Brief    : Multi-bank DRAM command scheduler. Tracks the open row of every
//            bank and turns one L2 request at a time into the minimal
//            PRE / ACT / RD / WR sequence over a 4-phase req/ack handshake.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dram_bank_sched #(
    parameter int NUM_OF_BANKS = 8,
    parameter int ROW_W        = 7,
    parameter int COL_W        = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int CLOSE_PAGE   = 0,
    parameter int BANK_W       = $clog2(NUM_OF_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [BANK_W-1:0]     req_bank,
    input  logic [ROW_W-1:0]      req_row,
    input  logic [COL_W-1:0]      req_col,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  cmd_req,
    input  logic                  cmd_ack,
    output logic [1:0]            cmd,
    output logic [BANK_W-1:0]     cmd_bank,
    output logic [ROW_W-1:0]      cmd_row,
    output logic [COL_W-1:0]      cmd_col,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    // Open-row table is sized to the full bank address space so any bank
    // index can be looked up; entries at or above NUM_OF_BANKS stay unused.
    localparam int                c_TABLE = 1 << BANK_W;
    localparam logic [BANK_W:0]   c_NB    = NUM_OF_BANKS[BANK_W:0];
    localparam logic              c_CLOSE = (CLOSE_PAGE != 0);

    localparam logic [1:0] c_CMD_PRE = 2'b00;
    localparam logic [1:0] c_CMD_ACT = 2'b01;
    localparam logic [1:0] c_CMD_RD  = 2'b10;
    localparam logic [1:0] c_CMD_WR  = 2'b11;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_idle_rdy;
    logic                  r_rw;
    logic                  r_err;
    logic                  r_after_acc;
    logic [DATA_WIDTH-1:0] r_rdata_cap;
    logic [c_TABLE-1:0]    r_open_valid;
    logic [ROW_W-1:0]      r_open_row [c_TABLE];

    logic w_accept;
    logic w_bad;
    logic w_hit;
    logic w_done;

    // A pending ack from the DRAM side always blocks acceptance.
    assign req_ready = r_idle_rdy & ~cmd_ack;
    assign w_accept  = req_valid & req_ready;
    assign w_bad     = ({1'b0, req_bank} >= c_NB);
    assign w_hit     = r_open_valid[req_bank] && (r_open_row[req_bank] == req_row);
    // Sequence ends after the access (open page) or after the trailing PRE.
    assign w_done    = ((cmd == c_CMD_PRE) && r_after_acc) || (cmd[1] && !c_CLOSE);

    // Next-state decode of the request/handshake sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_accept) w_state_nxt = w_bad ? c_ST_RESP : c_ST_ISSUE;
            c_ST_ISSUE:   if (cmd_ack) w_state_nxt = c_ST_RELEASE;
            c_ST_RELEASE: if (!cmd_ack) w_state_nxt = w_done ? c_ST_RESP : c_ST_ISSUE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Registered state, command outputs, bank table, response and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_idle_rdy   <= 1'b0;
            r_rw         <= 1'b0;
            r_err        <= 1'b0;
            r_after_acc  <= 1'b0;
            r_rdata_cap  <= '0;
            r_open_valid <= '0;
            for (int i = 0; i < c_TABLE; i++) r_open_row[i] <= '0;
            cmd_req      <= 1'b0;
            cmd          <= c_CMD_PRE;
            cmd_bank     <= '0;
            cmd_row      <= '0;
            cmd_col      <= '0;
            cmd_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_rdy <= (w_state_nxt == c_ST_IDLE);
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_rw        <= req_rw;
                        r_err       <= w_bad;
                        r_after_acc <= 1'b0;
                        if (!w_bad) begin
                            cmd_req   <= 1'b1;
                            cmd_bank  <= req_bank;
                            cmd_row   <= req_row;
                            cmd_col   <= req_col;
                            cmd_wdata <= req_wdata;
                            if (w_hit) begin
                                cmd <= req_rw ? c_CMD_WR : c_CMD_RD;
                                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                            end else begin
                                cmd <= r_open_valid[req_bank] ? c_CMD_PRE : c_CMD_ACT;
                                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                            end
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (cmd_ack) begin
                        cmd_req <= 1'b0;
                        case (cmd)
                            c_CMD_PRE: r_open_valid[cmd_bank] <= 1'b0;
                            c_CMD_ACT: begin
                                r_open_valid[cmd_bank] <= 1'b1;
                                r_open_row[cmd_bank]   <= cmd_row;
                            end
                            c_CMD_RD:  r_rdata_cap <= dram_rdata;
                            default:   ;
                        endcase
                    end
                end
                c_ST_RELEASE: begin
                    if (!cmd_ack && !w_done) begin
                        cmd_req <= 1'b1;
                        case (cmd)
                            c_CMD_PRE: cmd <= c_CMD_ACT;
                            c_CMD_ACT: cmd <= r_rw ? c_CMD_WR : c_CMD_RD;
                            default: begin
                                cmd         <= c_CMD_PRE;
                                r_after_acc <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_err;
                    if (!r_err && !r_rw) rsp_data <= r_rdata_cap;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_bank_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_bank_sched
// Brief    : Scoreboard bench for dram_bank_sched. Instance 0 is open-page
//            with 6 banks, instance 1 is close-page with 8 banks. A request
//            model predicts command streams and responses into queues that
//            per-instance monitors pop and compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_bank_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic       req_valid_v [2];
    logic       req_ready_v [2];
    logic       req_rw_v    [2];
    logic [2:0] req_bank_v  [2];
    logic [6:0] req_row_v   [2];
    logic [2:0] req_col_v   [2];
    logic [7:0] req_wdata_v [2];
    logic       cmd_req_v   [2];
    logic       cmd_ack_v   [2];
    logic [1:0] cmd_v       [2];
    logic [2:0] cmd_bank_v  [2];
    logic [6:0] cmd_row_v   [2];
    logic [2:0] cmd_col_v   [2];
    logic [7:0] cmd_wdata_v [2];
    logic [7:0] dram_rdata_v[2];
    logic       rsp_valid_v [2];
    logic [7:0] rsp_data_v  [2];
    logic       rsp_err_v   [2];
    logic [15:0] hit_v      [2];
    logic [15:0] miss_v     [2];
    logic       ack_force   [2];
    int         ack_dly     [2];

    typedef struct {
        int       inst;
        logic [1:0] op;
        int       bank;
        int       row;
        int       col;
        int       wdata;
    } cmd_exp_t;

    typedef struct {
        int inst;
        bit err;
        int data;
        int hit;
        int miss;
        int cyc;
    } rsp_exp_t;

    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];

    // Behavioural model: what each bank holds open, counters, DRAM contents.
    int         m_nb    [2];
    bit         m_close [2];
    bit         m_open  [2][8];
    int         m_row   [2][8];
    int         m_hit   [2];
    int         m_miss  [2];
    int         m_rdata [2];
    logic [7:0] m_mem   [2][8192];

    function automatic logic [7:0] init_val(input int inst, input int a);
        return 8'((a * 37) ^ (inst * 91) ^ (a >> 5));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dram_bank_sched #(
            .NUM_OF_BANKS (g == 0 ? 6 : 8),
            .ROW_W        (7),
            .COL_W        (3),
            .DATA_WIDTH   (8),
            .CLOSE_PAGE   (g)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid_v[g]),
            .req_ready  (req_ready_v[g]),
            .req_rw     (req_rw_v[g]),
            .req_bank   (req_bank_v[g]),
            .req_row    (req_row_v[g]),
            .req_col    (req_col_v[g]),
            .req_wdata  (req_wdata_v[g]),
            .cmd_req    (cmd_req_v[g]),
            .cmd_ack    (cmd_ack_v[g]),
            .cmd        (cmd_v[g]),
            .cmd_bank   (cmd_bank_v[g]),
            .cmd_row    (cmd_row_v[g]),
            .cmd_col    (cmd_col_v[g]),
            .cmd_wdata  (cmd_wdata_v[g]),
            .dram_rdata (dram_rdata_v[g]),
            .rsp_valid  (rsp_valid_v[g]),
            .rsp_data   (rsp_data_v[g]),
            .rsp_err    (rsp_err_v[g]),
            .hit_count  (hit_v[g]),
            .miss_count (miss_v[g])
        );

        // DRAM-side responder: follows cmd_req after ack_dly edges, holds the array.
        logic       ack_r   = 1'b0;
        int         cnt     = 0;
        logic [7:0] rdata_r = 8'h00;
        logic [7:0] rmem [8192];
        logic [12:0] addr;

        initial for (int k = 0; k < 8192; k++) rmem[k] = init_val(g, k);

        assign cmd_ack_v[g]    = ack_r | ack_force[g];
        assign dram_rdata_v[g] = rdata_r;

        always @(posedge clk) begin
            if (cmd_req_v[g] != ack_r) begin
                if (cnt + 1 >= ack_dly[g]) begin
                    ack_r <= cmd_req_v[g];
                    cnt   <= 0;
                    addr   = {cmd_bank_v[g], cmd_row_v[g], cmd_col_v[g]};
                    if (cmd_req_v[g] && cmd_v[g] == 2'b11) rmem[addr] = cmd_wdata_v[g];
                    if (cmd_req_v[g] && cmd_v[g] == 2'b10) rdata_r <= rmem[addr];
                    else                                   rdata_r <= 8'($urandom);
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                cnt <= 0;
            end
        end

        // Monitor: pops expected commands on each cmd_req rise and responses on rsp_valid.
        logic        prev_req = 1'b0;
        logic [22:0] hold     = '0;
        cmd_exp_t    ce;
        rsp_exp_t    re;

        always @(negedge clk) begin
            if (cmd_req_v[g] && !prev_req) begin
                if (cmd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_cmd: inst %0d issued cmd %0d with none required", g, cmd_v[g]);
                end else begin
                    ce = cmd_q.pop_front();
                    check("cmd_inst", g, ce.inst);
                    check("cmd_op", cmd_v[g], ce.op);
                    check("cmd_bank", cmd_bank_v[g], ce.bank);
                    if (ce.op == 2'b01) check("cmd_row", cmd_row_v[g], ce.row);
                    if (ce.op[1])       check("cmd_col", cmd_col_v[g], ce.col);
                    if (ce.op == 2'b11) check("cmd_wdata", cmd_wdata_v[g], ce.wdata);
                end
                hold = {cmd_v[g], cmd_bank_v[g], cmd_row_v[g], cmd_col_v[g], cmd_wdata_v[g]};
            end else if (cmd_req_v[g]) begin
                check("cmd_stable", {cmd_v[g], cmd_bank_v[g], cmd_row_v[g], cmd_col_v[g], cmd_wdata_v[g]}, hold);
            end
            prev_req = cmd_req_v[g];

            if (rsp_valid_v[g]) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: inst %0d pulsed rsp_valid with none required", g);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_inst", g, re.inst);
                    check("rsp_err", rsp_err_v[g], re.err);
                    check("rsp_data", rsp_data_v[g], re.data);
                    check("hit_count", hit_v[g], re.hit);
                    check("miss_count", miss_v[g], re.miss);
                    check("rsp_cycle", cyc, re.cyc);
                    check("cmds_done", cmd_q.size(), 0);
                end
            end
        end
    end

    task automatic push_cmd(input int inst, input logic [1:0] op, input int bank, row, col, wdata);
        cmd_exp_t c;
        c = '{inst, op, bank, row, col, wdata};
        cmd_q.push_back(c);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 8; b++) m_open[i][b] = 1'b0;
            m_hit[i]   = 0;
            m_miss[i]  = 0;
            m_rdata[i] = 0;
        end
    endtask

    // Issue one request, predict its commands and response, wait for completion.
    task automatic do_req(input int inst, input bit rw, input int bank, row, col, wdata, input int a);
        int       n;
        int       to;
        int       maddr;
        bit       err;
        rsp_exp_t r;
        ack_dly[inst] = a;
        @(negedge clk);
        to = 0;
        while (!req_ready_v[inst] && to < 100) begin
            @(negedge clk);
            to++;
        end
        if (!req_ready_v[inst]) begin
            check("req_ready_timeout", req_ready_v[inst], 1);
            return;
        end
        err = (bank >= m_nb[inst]);
        n   = 0;
        if (!err) begin
            if (m_open[inst][bank] && m_row[inst][bank] == row) begin
                if (m_hit[inst] < 65535) m_hit[inst]++;
            end else begin
                if (m_miss[inst] < 65535) m_miss[inst]++;
                if (m_open[inst][bank]) begin
                    push_cmd(inst, 2'b00, bank, row, col, wdata);
                    n++;
                end
                push_cmd(inst, 2'b01, bank, row, col, wdata);
                n++;
                m_open[inst][bank] = 1'b1;
                m_row[inst][bank]  = row;
            end
            push_cmd(inst, rw ? 2'b11 : 2'b10, bank, row, col, wdata);
            n++;
            if (m_close[inst]) begin
                push_cmd(inst, 2'b00, bank, row, col, wdata);
                n++;
                m_open[inst][bank] = 1'b0;
            end
            maddr = bank * 1024 + row * 8 + col;
            if (rw) m_mem[inst][maddr] = 8'(wdata);
            else    m_rdata[inst]      = int'(m_mem[inst][maddr]);
        end
        // Accepted at the next edge; rsp_valid is registered one edge after
        // the RESP state, and each command spends A+1 cycles per phase.
        r = '{inst, err, m_rdata[inst], m_hit[inst], m_miss[inst], cyc + 2 + n * (2 * a + 2)};
        rsp_q.push_back(r);
        req_rw_v[inst]    = rw;
        req_bank_v[inst]  = 3'(bank);
        req_row_v[inst]   = 7'(row);
        req_col_v[inst]   = 3'(col);
        req_wdata_v[inst] = 8'(wdata);
        req_valid_v[inst] = 1'b1;
        @(negedge clk);
        req_valid_v[inst] = 1'b0;
        req_bank_v[inst]  = 3'($urandom);
        req_row_v[inst]   = 7'($urandom);
        req_col_v[inst]   = 3'($urandom);
        req_wdata_v[inst] = 8'($urandom);
        to = 0;
        while (rsp_q.size() != 0 && to < 300) begin
            @(negedge clk);
            to++;
        end
        if (rsp_q.size() != 0) begin
            check("rsp_timeout", rsp_q.size(), 0);
            rsp_q.delete();
            cmd_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        int row;
        m_nb    = '{6, 8};
        m_close = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            req_valid_v[i] = 1'b0;
            req_rw_v[i]    = 1'b0;
            req_bank_v[i]  = '0;
            req_row_v[i]   = '0;
            req_col_v[i]   = '0;
            req_wdata_v[i] = '0;
            ack_force[i]   = 1'b0;
            ack_dly[i]     = 1;
            for (int k = 0; k < 8192; k++) m_mem[i][k] = init_val(i, k);
        end
        model_reset();

        // Reset values, then release.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", req_ready_v[i], 0);
            check("rst_cmd_req", cmd_req_v[i], 0);
            check("rst_cmd_fields", {cmd_v[i], cmd_bank_v[i], cmd_row_v[i], cmd_col_v[i], cmd_wdata_v[i]}, 0);
            check("rst_rsp", {rsp_valid_v[i], rsp_err_v[i], rsp_data_v[i]}, 0);
            check("rst_counters", {hit_v[i], miss_v[i]}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check("post_rst_ready", req_ready_v[i], 1);

        // Open-page directed: closed-bank write, row hit read, row conflict read.
        do_req(0, 1'b1, 2, 5, 1, 8'hA5, 1);
        do_req(0, 1'b0, 2, 5, 1, 0, 1);
        check("hit_read_data", rsp_data_v[0], 8'hA5);
        do_req(0, 1'b0, 2, 9, 0, 0, 1);
        check("conflict_miss", miss_v[0], 2);

        // Close-page: repeated row never hits.
        do_req(1, 1'b0, 0, 3, 0, 0, 1);
        do_req(1, 1'b0, 0, 3, 0, 0, 1);
        check("close_hit", hit_v[1], 0);
        check("close_miss", miss_v[1], 2);

        // Out-of-range banks on the 6-bank instance.
        do_req(0, 1'b0, 7, 0, 0, 0, 1);
        do_req(0, 1'b1, 6, 1, 2, 8'h3C, 2);

        // Stray ack in IDLE blocks acceptance; a withdrawn request latches nothing.
        ack_force[0] = 1'b1;
        @(negedge clk);
        req_valid_v[0] = 1'b1;
        req_bank_v[0]  = 3'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ack_blocks_ready", req_ready_v[0], 0);
        end
        req_valid_v[0] = 1'b0;
        ack_force[0]   = 1'b0;
        repeat (3) @(negedge clk);
        check("no_accept_cmd_req", cmd_req_v[0], 0);
        check("ready_after_stray_ack", req_ready_v[0], 1);

        // Reset in the middle of an ACT.
        ack_dly[0] = 3;
        push_cmd(0, 2'b01, 4, 1, 0, 0);
        req_rw_v[0]    = 1'b0;
        req_bank_v[0]  = 3'd4;
        req_row_v[0]   = 7'd1;
        req_col_v[0]   = 3'd0;
        req_valid_v[0] = 1'b1;
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        to = 0;
        while (cmd_q.size() != 0 && to < 50) begin
            @(negedge clk);
            to++;
        end
        check("mid_act_cmd_req", cmd_req_v[0], 1);
        rst = 1'b1;
        cmd_q.delete();
        rsp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_cmd_req", cmd_req_v[0], 0);
        check("mid_rst_counters", {hit_v[0], miss_v[0]}, 0);
        check("mid_rst_ready", req_ready_v[0], 0);
        to = 0;
        while (!req_ready_v[0] && to < 20) begin
            @(negedge clk);
            to++;
        end
        check("mid_rst_ready_return", req_ready_v[0], 1);
        do_req(0, 1'b0, 4, 1, 0, 0, 1);

        // Randomised traffic across both instances.
        for (int k = 0; k < 160; k++) begin
            row = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 3);
            do_req($urandom_range(0, 1), 1'($urandom), $urandom_range(0, 7), row,
                   $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(1, 3));
        end

        repeat (5) @(negedge clk);
        check("queues_drained", cmd_q.size() + rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
